// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one instruction/data memory between the fetch
// port and the MEM-stage data port. One access at a time, held on mem_en for
// WAIT_CYC cycles, then acknowledged to the port that won it. Data wins by
// default; a starvation counter forces a fetch win after STARVE_MAX
// consecutive fetch losses.
// Optional feature: define MEM_ARB_PERF_EN to add the per-port stall counters
// perf_if_stall / perf_d_stall.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int WAIT_CYC   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arb_hold,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_if_stall,
  output logic [15:0]   perf_d_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  // Both limits fit in 4 bits (legal range 1..15).
  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYC - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [3:0]    wait_cnt, wait_d;
  logic [3:0]    starve_cnt, starve_d;

  logic          if_gnt_d, d_gnt_d, if_ack_d, d_ack_d;
  logic [DW-1:0] if_rdata_d, d_rdata_d;
  logic          mem_en_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;

  logic          grant_any;
  logic          pick_if;

  // Winner selection: data by default, fetch when it has lost too often.
  always_comb begin
    grant_any = !arb_hold && (if_req || d_req);
    pick_if   = if_req && (!d_req || (starve_cnt == STARVE_LIM));
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    wait_d      = wait_cnt;
    starve_d    = starve_cnt;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;

    unique case (state_q)
      IDLE, DONE: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (grant_any) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          wait_d   = WAIT_INIT;
          if (pick_if) begin
            owner_d    = OWN_IF;
            if_gnt_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end else begin
            owner_d     = OWN_D;
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Fetch was also waiting and lost this round.
            if (if_req && (starve_cnt != STARVE_LIM)) begin
              starve_d = starve_cnt + 4'd1;
            end
          end
        end
      end

      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          state_d  = DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          wait_d = wait_cnt - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wait_cnt   <= wait_d;
      starve_cnt <= starve_d;
      if_gnt     <= if_gnt_d;
      d_gnt      <= d_gnt_d;
      if_ack     <= if_ack_d;
      d_ack      <= d_ack_d;
      if_rdata   <= if_rdata_d;
      d_rdata    <= d_rdata_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating count of cycles each port requested without being granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_if_stall <= '0;
      perf_d_stall  <= '0;
    end else begin
      if (if_req && !if_gnt && (perf_if_stall != 16'hFFFF)) begin
        perf_if_stall <= perf_if_stall + 16'd1;
      end
      if (d_req && !d_gnt && (perf_d_stall != 16'hFFFF)) begin
        perf_d_stall <= perf_d_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed steps for the listed scenarios followed by
// greedy and randomized traffic checked against a transaction-timing model
// (grant one cycle after a free arbitration, ack WAIT_CYC cycles after grant).
module tb_mem_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int W    = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arb_hold;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]   perf_if_stall, perf_d_stall;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .arb_hold(arb_hold),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ack(if_ack),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall)
`endif
  );

  // Memory: unwritten words read back a fixed address-derived pattern.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 10'd10) return 32'h2800_0005;
    return 32'hA500_0000 | (32'(a) * 32'h0001_0101);
  endfunction

  logic [DW-1:0] mem     [0:1023];
  bit            mem_vld [0:1023];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
  end

  always_comb mem_rdata = mem_vld[mem_addr] ? mem[mem_addr] : init_word(mem_addr);

  // Reference model state.
  logic [DW-1:0] ref_mem [0:1023];
  int            m_cyc, m_gcyc, m_starve;
  bit            m_fetch, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_exp_rd, m_if_rdata, m_d_rdata;
  bit            if_busy, d_busy;
  bit            gq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; arb_hold = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    m_cyc = 0; m_gcyc = -100; m_starve = 0; m_fetch = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_exp_rd = '0;
    m_if_rdata = '0; m_d_rdata = '0; if_busy = 1'b0; d_busy = 1'b0;
  endtask

  // Cycle loop: check outputs against the model, update requesters, predict.
  task automatic run_engine(input int n_cyc, input bit greedy);
    for (int k = 0; k < n_cyc; k++) begin
      bit e_ig, e_dg, e_ia, e_da, e_en;
      e_en = (m_cyc >= m_gcyc) && (m_cyc < m_gcyc + W);
      e_ig = (m_cyc == m_gcyc) && m_fetch;
      e_dg = (m_cyc == m_gcyc) && !m_fetch;
      e_ia = (m_cyc == m_gcyc + W) && m_fetch;
      e_da = (m_cyc == m_gcyc + W) && !m_fetch;
      if (e_ia) m_if_rdata = m_exp_rd;
      if (e_da && !m_we) m_d_rdata = m_exp_rd;

      check("ctl", {if_gnt, d_gnt, if_ack, d_ack, mem_en}, {e_ig, e_dg, e_ia, e_da, e_en});
      if (e_en)
        check("mem_acc", {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)},
              {m_we, m_addr, (m_we ? m_wdata : 32'h0)});
      check("if_rdata", if_rdata, m_if_rdata);
      check("d_rdata", d_rdata, m_d_rdata);

      if (if_gnt) begin gq.push_back(1'b1); if_req = 1'b0; if_busy = 1'b1; end
      if (d_gnt)  begin gq.push_back(1'b0); d_req  = 1'b0; d_busy  = 1'b1; end
      if (if_ack) if_busy = 1'b0;
      if (d_ack)  d_busy  = 1'b0;
      if (!if_req && !if_busy && (greedy || $urandom_range(0, 99) < 40)) begin
        if_req  = 1'b1;
        if_addr = greedy ? 10'(k) : 10'($urandom_range(0, 31));
      end
      if (!d_req && !d_busy && (greedy || $urandom_range(0, 99) < 40)) begin
        d_req   = 1'b1;
        d_we    = greedy ? 1'b0 : 1'($urandom_range(0, 1));
        d_addr  = 10'($urandom_range(0, 31));
        d_wdata = $urandom;
      end
      arb_hold = greedy ? 1'b0 : ($urandom_range(0, 99) < 15);

      if ((m_cyc >= m_gcyc + W) && !arb_hold && (if_req || d_req)) begin
        m_fetch = if_req && (!d_req || m_starve == SMAX);
        if (m_fetch) begin
          m_starve = 0; m_addr = if_addr; m_we = 1'b0;
        end else begin
          if (if_req) m_starve = (m_starve == SMAX) ? SMAX : m_starve + 1;
          m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
        end
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_exp_rd = ref_mem[m_addr];
        m_gcyc = m_cyc + 1;
      end
      m_cyc++;
      step();
    end
  endtask

  initial begin
    logic [5:0] seq;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
    rst_n = 1'b0; arb_hold = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset values.
    do_reset();
    check("rst_ctl", {if_gnt, d_gnt, if_ack, d_ack, mem_en, mem_we}, 6'b0);
    check("rst_mem", {mem_addr, mem_wdata}, 42'b0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'b0);

    // Single fetch of word 10.
    if_req = 1'b1; if_addr = 10'd10;
    step();
    check("f_gnt", {if_gnt, d_gnt, mem_en, mem_we}, 4'b1010);
    check("f_addr", mem_addr, 10'd10);
    if_req = 1'b0;
    step();
    check("f_hold", {if_gnt, mem_en, if_ack}, 3'b010);
    step();
    check("f_ack", {if_ack, mem_en}, 2'b10);
    check("f_rdata", if_rdata, 32'h2800_0005);
    step();
    check("f_after", {if_ack, if_rdata}, {1'b0, 32'h2800_0005});

    // Load and fetch together: data first, fetch granted in DONE.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20; if_req = 1'b1; if_addr = 10'd30;
    step();
    check("c_dgnt", {d_gnt, if_gnt, mem_addr}, {2'b10, 10'd20});
    d_req = 1'b0;
    step();
    step();
    check("c_dack", {d_ack, mem_en, d_rdata}, {2'b10, init_word(10'd20)});
    step();
    check("c_ignt", {if_gnt, mem_en, d_ack, mem_addr}, {3'b110, 10'd30});
    if_req = 1'b0;
    step();
    step();
    check("c_iack", {if_ack, if_rdata}, {1'b1, init_word(10'd30)});

    // Store, then read it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd100; d_wdata = 32'hDEAD_BEEF;
    ref_mem[100] = 32'hDEAD_BEEF;
    step();
    check("s_c1", {d_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {3'b111, 10'd100, 32'hDEAD_BEEF});
    d_req = 1'b0;
    step();
    check("s_c2", {mem_en, mem_we, mem_addr}, {2'b11, 10'd100});
    step();
    check("s_ack", {d_ack, mem_en, mem_we, d_rdata}, {3'b100, init_word(10'd20)});
    d_req = 1'b1; d_we = 1'b0;
    step();
    d_req = 1'b0;
    step();
    step();
    check("s_read", {d_ack, d_rdata}, {1'b1, 32'hDEAD_BEEF});

    // arb_hold raised during an access.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd5;
    step();
    check("h_dgnt", d_gnt, 1'b1);
    d_req = 1'b0; arb_hold = 1'b1; if_req = 1'b1; if_addr = 10'd7;
    step();
    step();
    check("h_dack", {d_ack, if_gnt, d_rdata}, {2'b10, init_word(10'd5)});
    step();
    check("h_held1", {if_gnt, mem_en}, 2'b00);
    step();
    check("h_held2", {if_gnt, mem_en}, 2'b00);
    arb_hold = 1'b0;
    step();
    check("h_gnt", {if_gnt, mem_addr}, {1'b1, 10'd7});
    if_req = 1'b0;
    step();
    step();
    check("h_iack", {if_ack, if_rdata}, {1'b1, init_word(10'd7)});

    // Reset during an access aborts it without an ack.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd40;
    step();
    check("r_dgnt", d_gnt, 1'b1);
    d_req = 1'b0; rst_n = 1'b0;
    step();
    check("r_state", {mem_en, d_gnt, d_ack, mem_addr, if_rdata, d_rdata}, 77'b0);
    rst_n = 1'b1;
    step();
    check("r_noack1", {d_ack, mem_en}, 2'b00);
    step();
    check("r_noack2", {d_ack, if_ack}, 2'b00);
    if_req = 1'b1; if_addr = 10'd10;
    step();
    check("r_gnt", {if_gnt, mem_en}, 2'b11);
    if_req = 1'b0;
    step();
    step();
    check("r_ack", {if_ack, if_rdata}, {1'b1, 32'h2800_0005});

    // Starvation: both requesters always re-request.
    do_reset();
    gq.delete();
    run_engine(40, 1'b1);
    check("starve_cnt", (gq.size() >= 6), 1'b1);
    seq = '0;
    for (int i = 0; i < 6; i++) if (i < gq.size()) seq[5-i] = gq[i];
    check("starve_seq", seq, 6'b000010);

    // Randomized traffic with random arb_hold.
    run_engine(600, 1'b0);

`ifdef MEM_ARB_PERF_EN
    do_reset();
    arb_hold = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd3;
    repeat (5) step();
    check("perf_d", perf_d_stall, 16'd5);
    check("perf_if", perf_if_stall, 16'd0);
    d_req = 1'b0; arb_hold = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
